// File: rtl/inst_micro_tlb.sv
// Fully-associative instruction micro-TLB: one-cycle hit path, refill from the
// shared main TLB on miss, round-robin replacement, flush on TLB write/ASID change.
module inst_micro_tlb #(
    parameter int ENTRIES   = 4,
    parameter int ADDR_W    = 32,
    parameter int PAGE_BITS = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    input  logic [ADDR_W-1:0]           req_va,
    output logic                        req_ready,
    input  logic                        cancel,
    input  logic                        flush,
    output logic                        resp_valid,
    output logic [ADDR_W-1:0]           resp_va,
    output logic [ADDR_W-1:0]           resp_pa,
    output logic                        resp_cached,
    output logic                        resp_miss,
    output logic                        resp_invalid,
    output logic                        resp_error,
    output logic                        mtlb_req,
    output logic [ADDR_W-1:0]           mtlb_va,
    input  logic                        mtlb_ack,
    input  logic                        mtlb_hit,
    input  logic                        mtlb_valid,
    input  logic                        mtlb_error,
    input  logic                        mtlb_cached,
    input  logic [ADDR_W-PAGE_BITS-1:0] mtlb_pfn,
    output logic [1:0]                  dbg_state
);

    localparam int VPN_W = ADDR_W - PAGE_BITS;
    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]          state, state_n;
    logic                s1_valid;
    logic [ADDR_W-1:0]   s1_va;
    logic                stale;
    logic                redo;
    logic [IDX_W-1:0]    rr_ptr;

    logic [ENTRIES-1:0]  ent_v;
    logic [VPN_W-1:0]    ent_vpn [ENTRIES];
    logic [VPN_W-1:0]    ent_pfn [ENTRIES];
    logic                ent_c   [ENTRIES];

    logic [VPN_W-1:0]    cap_pfn;
    logic                cap_cached, cap_miss, cap_inv, cap_err;

    logic                hit_any, s1_hit, hit_c;
    logic [VPN_W-1:0]    hit_pfn;
    logic                resp_hit, resp_cap;
    logic                mt_good, ack_live, drop_ack, fill_en, capture_en;
    logic                cap_fault;

    // At most one entry can match, so OR-reducing the matching lanes is a mux.
    always_comb begin
        hit_any = 1'b0;
        hit_pfn = '0;
        hit_c   = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_v[i] && ent_vpn[i] == s1_va[ADDR_W-1:PAGE_BITS]) begin
                hit_any = 1'b1;
                hit_pfn = hit_pfn | ent_pfn[i];
                hit_c   = hit_c | ent_c[i];
            end
        end
    end

    assign s1_hit = s1_valid & hit_any;

    // Handshake: a request transfers on a clock edge where req_valid & req_ready;
    // a response is a single-cycle resp_valid pulse with no back-pressure;
    // mtlb_req stays high with a stable mtlb_va until the cycle mtlb_ack is seen.
    always_comb begin
        req_ready = 1'b0;
        resp_hit  = 1'b0;
        resp_cap  = 1'b0;
        state_n   = state;
        case (state)
            ST_IDLE: begin
                req_ready = (!s1_valid | s1_hit) & !flush & !cancel;
                if (s1_valid && !cancel) begin
                    if (s1_hit) resp_hit = !flush;
                    else        state_n  = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mtlb_ack) begin
                    if (stale || cancel)      state_n = ST_IDLE;
                    else if (!(flush || redo)) state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                req_ready = !flush & !cancel;
                resp_cap  = !flush & !cancel;
                state_n   = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign mt_good    = mtlb_hit & mtlb_valid & !mtlb_error;
    assign ack_live   = (state == ST_REFILL) & mtlb_ack;
    // An ack that overlaps or follows a flush belongs to stale main-TLB contents.
    assign drop_ack   = flush | redo;
    assign fill_en    = ack_live & !drop_ack & mt_good;
    assign capture_en = ack_live & !drop_ack & !stale & !cancel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            s1_valid <= 1'b0;
            s1_va    <= '0;
            stale    <= 1'b0;
            redo     <= 1'b0;
        end else begin
            state <= state_n;
            if (req_valid && req_ready) begin
                s1_valid <= 1'b1;
                s1_va    <= req_va;
            end else if (cancel || resp_hit || resp_cap) begin
                s1_valid <= 1'b0;
            end
            if (state_n != ST_REFILL)     stale <= 1'b0;
            else if (state == ST_REFILL && cancel) stale <= 1'b1;
            if (state_n != ST_REFILL)     redo <= 1'b0;
            else if (ack_live)            redo <= 1'b0;
            else if (state == ST_REFILL && flush) redo <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ent_v  <= '0;
            rr_ptr <= '0;
        end else if (fill_en) begin
            ent_v[rr_ptr] <= 1'b1;
            rr_ptr        <= rr_ptr + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            ent_vpn[rr_ptr] <= s1_va[ADDR_W-1:PAGE_BITS];
            ent_pfn[rr_ptr] <= mtlb_pfn;
            ent_c[rr_ptr]   <= mtlb_cached;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_pfn    <= '0;
            cap_cached <= 1'b0;
            cap_miss   <= 1'b0;
            cap_inv    <= 1'b0;
            cap_err    <= 1'b0;
        end else if (capture_en) begin
            cap_pfn    <= mt_good ? mtlb_pfn : '0;
            cap_cached <= mt_good & mtlb_cached;
            cap_err    <= mtlb_error;
            cap_miss   <= !mtlb_error & !mtlb_hit;
            cap_inv    <= !mtlb_error & mtlb_hit & !mtlb_valid;
        end
    end

    assign cap_fault = cap_err | cap_miss | cap_inv;

    always_comb begin
        resp_valid   = resp_hit | resp_cap;
        resp_va      = '0;
        resp_pa      = '0;
        resp_cached  = 1'b0;
        resp_miss    = 1'b0;
        resp_invalid = 1'b0;
        resp_error   = 1'b0;
        if (resp_hit) begin
            resp_va     = s1_va;
            resp_pa     = {hit_pfn, s1_va[PAGE_BITS-1:0]};
            resp_cached = hit_c;
        end else if (resp_cap) begin
            resp_va      = s1_va;
            resp_pa      = cap_fault ? '0 : {cap_pfn, s1_va[PAGE_BITS-1:0]};
            resp_cached  = cap_cached;
            resp_miss    = cap_miss;
            resp_invalid = cap_inv;
            resp_error   = cap_err;
        end
    end

    assign mtlb_req  = (state == ST_REFILL);
    assign mtlb_va   = mtlb_req ? s1_va : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_inst_micro_tlb.sv
// Directed bench for inst_micro_tlb with a scripted main-TLB responder.
module tb_inst_micro_tlb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, cancel, flush;
    logic [31:0] req_va;
    logic        req_ready, resp_valid, resp_cached, resp_miss, resp_invalid, resp_error;
    logic [31:0] resp_va, resp_pa;
    logic        mtlb_req, mtlb_ack, mtlb_hit, mtlb_valid, mtlb_error, mtlb_cached;
    logic [31:0] mtlb_va;
    logic [19:0] mtlb_pfn;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inst_micro_tlb #(.ENTRIES(4), .ADDR_W(32), .PAGE_BITS(12)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_va(req_va), .req_ready(req_ready),
        .cancel(cancel), .flush(flush),
        .resp_valid(resp_valid), .resp_va(resp_va), .resp_pa(resp_pa),
        .resp_cached(resp_cached), .resp_miss(resp_miss),
        .resp_invalid(resp_invalid), .resp_error(resp_error),
        .mtlb_req(mtlb_req), .mtlb_va(mtlb_va), .mtlb_ack(mtlb_ack),
        .mtlb_hit(mtlb_hit), .mtlb_valid(mtlb_valid), .mtlb_error(mtlb_error),
        .mtlb_cached(mtlb_cached), .mtlb_pfn(mtlb_pfn),
        .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Main-TLB responder: acks mt_delay cycles after mtlb_req is first seen.
    int          mt_delay = 1;
    logic        mt_hit = 1'b1, mt_valid = 1'b1, mt_err = 1'b0, mt_cached = 1'b1;
    logic [19:0] mt_pfn = '0;
    int          mt_acks = 0;
    int          wait_cnt = 0;

    initial begin
        mtlb_ack = 1'b0; mtlb_hit = 1'b0; mtlb_valid = 1'b0;
        mtlb_error = 1'b0; mtlb_cached = 1'b0; mtlb_pfn = '0;
        forever begin
            @(posedge clk); #2;
            mtlb_ack = 1'b0;
            if (mtlb_req === 1'b1) begin
                if (wait_cnt >= mt_delay) begin
                    mtlb_ack    = 1'b1;
                    mtlb_hit    = mt_hit;
                    mtlb_valid  = mt_valid;
                    mtlb_error  = mt_err;
                    mtlb_cached = mt_cached;
                    mtlb_pfn    = mt_pfn;
                    mt_acks++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Starts one #1 after a posedge; returns at the sample point of the response.
    task automatic wait_resp(input string tag, input logic [31:0] va, input logic [31:0] exp_pa,
                             input logic exp_c, input logic e_err, input logic e_miss,
                             input logic e_inv, output int lat);
        bit got = 0;
        lat = 0;
        for (int n = 1; n <= 40 && !got; n++) begin
            #2;
            if (resp_valid === 1'b1) begin
                got = 1;
                lat = n;
                chk({tag, "_va"}, resp_va, va);
                chk({tag, "_pa"}, resp_pa, exp_pa);
                chk({tag, "_flags"}, {28'd0, resp_cached, resp_error, resp_miss, resp_invalid},
                    {28'd0, exp_c, e_err, e_miss, e_inv});
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic lookup(input string tag, input logic [31:0] va,
                          input logic mh, input logic mv, input logic me, input logic mc,
                          input logic [19:0] pfn, input int exp_refills,
                          input logic [31:0] exp_pa, input logic exp_c,
                          input logic e_err, input logic e_miss, input logic e_inv);
        int a0;
        int lat;
        bit acc = 0;
        mt_hit = mh; mt_valid = mv; mt_err = me; mt_cached = mc; mt_pfn = pfn;
        a0 = mt_acks;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b1;
            req_va    = va;
            #2;
            if (req_ready === 1'b1) acc = 1;
        end
        if (!acc) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(tag, va, exp_pa, exp_c, e_err, e_miss, e_inv, lat);
        if (exp_refills == 0) chk({tag, "_lat"}, lat, 1);
        chk({tag, "_refills"}, mt_acks - a0, exp_refills);
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    logic [31:0] va_tab [5] = '{32'h0001_0123, 32'h0002_0123, 32'h0003_0123, 32'h0004_0123, 32'h0005_0123};
    logic [19:0] pfn_tab[5] = '{20'h00A01, 20'h00B02, 20'h00C03, 20'h00D04, 20'h00E05};
    logic [31:0] pa_tab [5] = '{32'h00A0_1123, 32'h00B0_2123, 32'h00C0_3123, 32'h00D0_4123, 32'h00E0_5123};
    logic        c_tab  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int lat;
        int pulses;
        bit seen;
        logic [31:0] sva, spa;
        rst = 1'b1; req_valid = 1'b0; req_va = '0; cancel = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mtlb_req", mtlb_req, 0);
        chk("rst_resp_pa", resp_pa, 0);
        chk("rst_state", dbg_state, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Test 1: first touch refills, same page then hits in one cycle.
        lookup("t1_fill", 32'h8000_1004, 1, 1, 0, 1, 20'h01F00, 1, 32'h01F0_0004, 1, 0, 0, 0);
        lookup("t1_hit", 32'h8000_1FF0, 1, 1, 0, 1, 20'h0, 0, 32'h01F0_0FF0, 1, 0, 0, 0);

        // Test 2: five pages into four entries; the fifth evicts the first.
        pulse_flush();
        for (int i = 0; i < 5; i++)
            lookup($sformatf("t2_fill%0d", i), va_tab[i], 1, 1, 0, c_tab[i], pfn_tab[i], 1,
                   pa_tab[i], c_tab[i], 0, 0, 0);
        for (int i = 1; i < 5; i++)
            lookup($sformatf("t2_hit%0d", i), va_tab[i], 1, 1, 0, 1, 20'h0, 0,
                   pa_tab[i], c_tab[i], 0, 0, 0);
        lookup("t2_evicted", va_tab[0], 1, 1, 0, 1, pfn_tab[0], 1, pa_tab[0], 1, 0, 0, 0);

        // Test 3: faults are reported, never cached, and obey error > miss > invalid.
        lookup("t3_miss", 32'h0040_0000, 0, 0, 0, 1, 20'h12345, 1, 32'h0, 0, 0, 1, 0);
        lookup("t3_miss_again", 32'h0040_0000, 0, 0, 0, 1, 20'h12345, 1, 32'h0, 0, 0, 1, 0);
        lookup("t3_invalid", 32'h0041_0008, 1, 0, 0, 1, 20'h12345, 1, 32'h0, 0, 0, 0, 1);
        lookup("t3_err_miss", 32'h0042_0004, 0, 0, 1, 1, 20'h12345, 1, 32'h0, 0, 1, 0, 0);
        lookup("t3_err_hit", 32'h0043_0004, 1, 1, 1, 1, 20'h12345, 1, 32'h0, 0, 1, 0, 0);
        lookup("t3_err_again", 32'h0043_0004, 1, 1, 0, 1, 20'h54321, 1, 32'h5432_1004, 1, 0, 0, 0);

        // Test 4: flush in the ack cycle discards the result and reissues the refill.
        mt_delay = 2; mt_hit = 1; mt_valid = 1; mt_err = 0; mt_cached = 1; mt_pfn = 20'h12345;
        @(posedge clk); #1;
        req_valid = 1'b1; req_va = 32'h0060_0A00;
        #2; chk("t4_accept", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        a0 = mt_acks;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            #2;
            if (mtlb_ack === 1'b1) begin
                seen = 1;
                flush = 1'b1;
                #1; chk("t4_noresp_at_ack", resp_valid, 0);
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!seen) chk("t4_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        #2;
        chk("t4_reissue_req", mtlb_req, 1);
        chk("t4_reissue_va", mtlb_va, 32'h0060_0A00);
        chk("t4_noresp_after", resp_valid, 0);
        chk("t4_acks_first", mt_acks - a0, 1);
        wait_resp("t4_resp", 32'h0060_0A00, 32'h1234_5A00, 1, 0, 0, 0, lat);
        chk("t4_acks_total", mt_acks - a0, 2);
        lookup("t4_hit", 32'h0060_0004, 1, 1, 0, 1, 20'h0, 0, 32'h1234_5004, 1, 0, 0, 0);

        // Test 5: cancel mid-refill still fills but never responds.
        mt_delay = 3; mt_pfn = 20'h0ABCD;
        @(posedge clk); #1;
        req_valid = 1'b1; req_va = 32'h0070_0000;
        #2; chk("t5_accept", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        a0 = mt_acks;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            #2;
            if (mtlb_req === 1'b1) seen = 1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) chk("t5_req_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cancel = 1'b1; req_valid = 1'b1; req_va = 32'h0071_0000;
        #2; chk("t5_cancel_not_ready", req_ready, 0);
        @(posedge clk); #1;
        cancel = 1'b0; req_valid = 1'b0;
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            #2; if (resp_valid === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        chk("t5_no_resp", pulses, 0);
        chk("t5_acks", mt_acks - a0, 1);
        chk("t5_state_idle", dbg_state, 0);
        lookup("t5_hit", 32'h0070_0010, 1, 1, 0, 1, 20'h0, 0, 32'h0ABC_D010, 1, 0, 0, 0);

        // Test 6: eight back-to-back hits, then a flush mid-stream.
        mt_delay = 1;
        pulse_flush();
        for (int i = 0; i < 4; i++)
            lookup($sformatf("t6_fill%0d", i), 32'h1000_0000 + i * 32'h1000, 1, 1, 0, 1,
                   20'h30000 + 20'(i), 1, 32'h3000_0000 + i * 32'h1000, 1, 0, 0, 0);
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i < 8) begin
                req_valid = 1'b1;
                req_va    = 32'h1000_0000 + (i % 4) * 32'h1000 + i * 8;
            end else begin
                req_valid = 1'b0;
            end
            #2;
            if (i < 8) chk($sformatf("t6_ready%0d", i), req_ready, 1);
            if (i > 0) begin
                sva = 32'h1000_0000 + ((i - 1) % 4) * 32'h1000 + (i - 1) * 8;
                spa = 32'h3000_0000 + ((i - 1) % 4) * 32'h1000 + (i - 1) * 8;
                chk($sformatf("t6_stream_valid%0d", i - 1), resp_valid, 1);
                chk($sformatf("t6_stream_va%0d", i - 1), resp_va, sva);
                chk($sformatf("t6_stream_pa%0d", i - 1), resp_pa, spa);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_va = 32'h1000_1000;
        #2; chk("t6_m0_ready", req_ready, 1);
        @(posedge clk); #1;
        req_va = 32'h1000_2008;
        #2;
        chk("t6_m0_resp", resp_valid, 1);
        chk("t6_m0_pa", resp_pa, 32'h3000_1000);
        @(posedge clk); #1;
        req_va = 32'h1000_3000; flush = 1'b1;
        #2;
        chk("t6_flush_ready", req_ready, 0);
        chk("t6_flush_resp", resp_valid, 0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        mt_pfn = 20'h30002; mt_hit = 1; mt_valid = 1; mt_err = 0; mt_cached = 1;
        a0 = mt_acks;
        wait_resp("t6_after_flush", 32'h1000_2008, 32'h3000_2008, 1, 0, 0, 0, lat);
        chk("t6_refilled", mt_acks - a0, 1);
        chk("t6_lat_gt1", (lat > 1) ? 32'd1 : 32'd0, 1);

        // Reset while refilling drops the request.
        mt_delay = 30;
        @(posedge clk); #1;
        req_valid = 1'b1; req_va = 32'h0090_0000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        #2; chk("rst_mid_req_before", mtlb_req, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("rst_mid_req_after", mtlb_req, 0);
        chk("rst_mid_state", dbg_state, 0);
        chk("rst_mid_ready", req_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
